// File: rtl/serial_cmd_sequencer.sv
// serial_cmd_sequencer: frames UART bytes into the command fifo, hands complete
// frames to the decoder and reports one status per frame.
module serial_cmd_sequencer #(
    parameter int FIFO_SIZE      = 16,
    parameter int BYTE_TIMEOUT   = 50000,
    parameter int DECODE_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_byte_valid,
    input  logic [7:0] rx_byte,
    output logic       fifo_push,
    output logic [7:0] fifo_in_data,
    output logic       fifo_clear,
    output logic       cmd_ready,
    input  logic       cmd_processed,
    input  logic       cmd_decode_success,
    output logic       cmd_processed_received,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_ok,
    output logic [2:0] err_code
);
    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int DT_W = $clog2(DECODE_TIMEOUT + 1);
    localparam logic [8:0]      MAX_LEN = 9'(FIFO_SIZE);
    localparam logic [BT_W-1:0] BT_LIM  = BT_W'(BYTE_TIMEOUT);
    localparam logic [DT_W-1:0] DT_LIM  = DT_W'(DECODE_TIMEOUT);

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_DECODE   = 3'd1;
    localparam logic [2:0] ERR_BYTE_TO  = 3'd2;
    localparam logic [2:0] ERR_OVERSIZE = 3'd3;
    localparam logic [2:0] ERR_DEC_TO   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_DISPATCH = 3'd3,
        ST_ACK      = 3'd4,
        ST_FLUSH    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [8:0]      count_q, count_d;
    logic [8:0]      expected_q, expected_d;
    logic [BT_W-1:0] byte_tmr_q, byte_tmr_d;
    logic [DT_W-1:0] dec_tmr_q, dec_tmr_d;
    logic [2:0]      err_pend_q, err_pend_d;
    logic            success_q, success_d;
    logic            push_q, push_d;
    logic [7:0]      data_q, data_d;
    logic            clear_q, clear_d;
    logic            ready_q, ready_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ok_q, ok_d;
    logic [2:0]      err_q, err_d;

    logic [BT_W-1:0] byte_tmr_nxt_s;
    logic [DT_W-1:0] dec_tmr_nxt_s;
    logic [8:0]      len_exp_s;
    logic            frame_full_s;

    // Next-state and registered-output computation for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        expected_d = expected_q;
        byte_tmr_d = byte_tmr_q;
        dec_tmr_d  = dec_tmr_q;
        err_pend_d = err_pend_q;
        success_d  = success_q;
        push_d     = 1'b0;
        data_d     = data_q;
        clear_d    = 1'b0;
        ready_d    = ready_q;
        ack_d      = ack_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        err_d      = err_q;

        byte_tmr_nxt_s = byte_tmr_q + BT_W'(1);
        dec_tmr_nxt_s  = dec_tmr_q + DT_W'(1);
        len_exp_s      = {1'b0, rx_byte} + 9'd6;
        // Length is only known once LEN has arrived, so expected==0 means "not yet".
        frame_full_s   = (expected_q != 9'd0) && (count_q == expected_q);

        case (state_q)
            ST_IDLE: begin
                count_d    = 9'd0;
                expected_d = 9'd0;
                byte_tmr_d = '0;
                dec_tmr_d  = '0;
                err_pend_d = ERR_NONE;
                if (rx_byte_valid && (rx_byte == 8'hFF)) begin
                    push_d  = 1'b1;
                    data_d  = rx_byte;
                    count_d = 9'd1;
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_COLLECT: begin
                if (frame_full_s) begin
                    ready_d    = 1'b1;
                    dec_tmr_d  = '0;
                    byte_tmr_d = '0;
                    state_d    = ST_DISPATCH;
                end else if (rx_byte_valid) begin
                    push_d     = 1'b1;
                    data_d     = rx_byte;
                    count_d    = count_q + 9'd1;
                    byte_tmr_d = '0;
                    if (count_q == 9'd3) begin
                        expected_d = len_exp_s;
                        if (len_exp_s > MAX_LEN) begin
                            err_pend_d = ERR_OVERSIZE;
                            state_d    = ST_DRAIN;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else if (byte_tmr_nxt_s == BT_LIM) begin
                    err_pend_d = ERR_BYTE_TO;
                    clear_d    = 1'b1;
                    state_d    = ST_FLUSH;
                end else begin
                    byte_tmr_d = byte_tmr_nxt_s;
                end
            end

            ST_DRAIN: begin
                // Swallow the rest of an oversize frame until the line goes quiet.
                if (rx_byte_valid) begin
                    byte_tmr_d = '0;
                end else if (byte_tmr_nxt_s == BT_LIM) begin
                    clear_d = 1'b1;
                    state_d = ST_FLUSH;
                end else begin
                    byte_tmr_d = byte_tmr_nxt_s;
                end
            end

            ST_DISPATCH: begin
                if (cmd_processed) begin
                    ready_d   = 1'b0;
                    success_d = cmd_decode_success;
                    ack_d     = 1'b1;
                    state_d   = ST_ACK;
                end else if (dec_tmr_nxt_s == DT_LIM) begin
                    ready_d    = 1'b0;
                    err_pend_d = ERR_DEC_TO;
                    clear_d    = 1'b1;
                    state_d    = ST_FLUSH;
                end else begin
                    dec_tmr_d = dec_tmr_nxt_s;
                end
            end

            ST_ACK: begin
                if (!cmd_processed) begin
                    ack_d = 1'b0;
                    if (success_q) begin
                        done_d     = 1'b1;
                        ok_d       = 1'b1;
                        err_d      = ERR_NONE;
                        count_d    = 9'd0;
                        expected_d = 9'd0;
                        byte_tmr_d = '0;
                        dec_tmr_d  = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        err_pend_d = ERR_DECODE;
                        clear_d    = 1'b1;
                        state_d    = ST_FLUSH;
                    end
                end else begin
                    state_d = ST_ACK;
                end
            end

            ST_FLUSH: begin
                done_d     = 1'b1;
                ok_d       = 1'b0;
                err_d      = err_pend_q;
                count_d    = 9'd0;
                expected_d = 9'd0;
                byte_tmr_d = '0;
                dec_tmr_d  = '0;
                state_d    = ST_IDLE;
            end

            default: begin
                ready_d = 1'b0;
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and all outputs register here; reset clears them at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            count_q    <= 9'd0;
            expected_q <= 9'd0;
            byte_tmr_q <= '0;
            dec_tmr_q  <= '0;
            err_pend_q <= 3'd0;
            success_q  <= 1'b0;
            push_q     <= 1'b0;
            data_q     <= 8'd0;
            clear_q    <= 1'b0;
            ready_q    <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            expected_q <= expected_d;
            byte_tmr_q <= byte_tmr_d;
            dec_tmr_q  <= dec_tmr_d;
            err_pend_q <= err_pend_d;
            success_q  <= success_d;
            push_q     <= push_d;
            data_q     <= data_d;
            clear_q    <= clear_d;
            ready_q    <= ready_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign fifo_push              = push_q;
    assign fifo_in_data           = data_q;
    assign fifo_clear             = clear_q;
    assign cmd_ready              = ready_q;
    assign cmd_processed_received = ack_q;
    assign busy                   = busy_q;
    assign frame_done             = done_q;
    assign frame_ok               = ok_q;
    assign err_code               = err_q;

    serial_cmd_sequencer_chk u_chk (
        .clk                    (clk),
        .rst                    (rst),
        .fifo_push              (push_q),
        .fifo_clear             (clear_q),
        .cmd_ready              (ready_q),
        .cmd_processed_received (ack_q),
        .busy                   (busy_q),
        .frame_done             (done_q),
        .err_code               (err_q)
    );
endmodule

// Protocol properties of the sequencer outputs.
module serial_cmd_sequencer_chk (
    input logic       clk,
    input logic       rst,
    input logic       fifo_push,
    input logic       fifo_clear,
    input logic       cmd_ready,
    input logic       cmd_processed_received,
    input logic       busy,
    input logic       frame_done,
    input logic [2:0] err_code
);
    a_no_push_in_hs: assert property (@(posedge clk) disable iff (!rst)
        fifo_push |-> !(cmd_ready || cmd_processed_received));
    a_clear_pulse: assert property (@(posedge clk) disable iff (!rst)
        fifo_clear |=> !fifo_clear);
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst)
        frame_done |=> !frame_done);
    a_hs_busy: assert property (@(posedge clk) disable iff (!rst)
        (cmd_ready || cmd_processed_received) |-> busy);
    a_err_range: assert property (@(posedge clk) disable iff (!rst)
        err_code <= 3'd4);
endmodule
